// File: rtl/multi_shifter_seq.sv
// ----------------------------------------------------------------------------
// multi_shifter_seq
//
// Purpose:
//   Sequential shifter. On accept it loads a WIDTH-bit word and a shift
//   distance. It then shifts the word left or right by at most STEP bits per
//   clock until the whole distance has been covered. Logical and arithmetic
//   modes are always built. The rotate mode is built only when the
//   MSHIFT_ROTATE_EN macro is defined; without it, mode 2'b10 is a logical
//   shift.
//
// Configuration macro:
//   MSHIFT_ROTATE_EN  - when defined, mode 2'b10 rotates (WIDTH-bit circular)
//
// Parameters:
//   WIDTH  data word width (>= 2)
//   STEP   max bits shifted per clock, power of 2 in 1..WIDTH
//   AW     width of amt, derived from WIDTH (do not override)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, accepted only while idle
//   din    in   word to shift, sampled on accept
//   amt    in   total shift distance, sampled on accept
//   dir    in   0 = left, 1 = right, sampled on accept
//   mode   in   00 logical, 01 arithmetic, 10 rotate, 11 logical
//   busy   out  high while a shift is in progress
//   done   out  one-cycle pulse when dout holds the final result
//   dout   out  shift register contents
// ----------------------------------------------------------------------------
module multi_shifter_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic {StIdle, StShift} state_e;

    localparam logic [AW:0] StepW  = (AW+1)'(STEP);
    localparam logic [AW:0] WidthW = (AW+1)'(WIDTH);

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_dout,  w_dout_d;
    logic [AW-1:0]    r_rem,   w_rem_d;
    logic             r_done,  w_done_d;
    logic             r_dir,   w_dir_d;
    logic             r_arith, w_arith_d;
`ifdef MSHIFT_ROTATE_EN
    logic             r_rot,   w_rot_d;
    logic [AW:0]      w_s_inv;
    logic [WIDTH-1:0] w_rol, w_ror;
`endif

    logic [AW-1:0]    w_s;
    logic [WIDTH-1:0] w_shl, w_shr, w_sra, w_shifted;

    // Bits moved this edge: min(STEP, rem). rem <= WIDTH-1, so when
    // STEP == WIDTH the clamp branch is never taken.
    always_comb begin
        if ({1'b0, r_rem} < StepW) begin
            w_s = r_rem;
        end else begin
            w_s = StepW[AW-1:0];
        end
    end

    assign w_shl = r_dout << w_s;
    assign w_shr = r_dout >> w_s;
    // The MSB never changes under an arithmetic right shift, so it still
    // holds the MSB latched on accept.
    assign w_sra = $signed(r_dout) >>> w_s;

`ifdef MSHIFT_ROTATE_EN
    // w_s is never 0 in SHIFT, so the complementary shift is at most WIDTH-1.
    assign w_s_inv = WidthW - {1'b0, w_s};
    assign w_rol   = (r_dout << w_s) | (r_dout >> w_s_inv);
    assign w_ror   = (r_dout >> w_s) | (r_dout << w_s_inv);
`endif

    always_comb begin
        w_shifted = r_dir ? (r_arith ? w_sra : w_shr) : w_shl;
`ifdef MSHIFT_ROTATE_EN
        if (r_rot) begin
            w_shifted = r_dir ? w_ror : w_rol;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_dout_d  = r_dout;
        w_rem_d   = r_rem;
        w_done_d  = 1'b0;
        w_dir_d   = r_dir;
        w_arith_d = r_arith;
`ifdef MSHIFT_ROTATE_EN
        w_rot_d   = r_rot;
`endif
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_dout_d  = din;
                    w_rem_d   = amt;
                    w_dir_d   = dir;
                    w_arith_d = (mode == 2'b01);
`ifdef MSHIFT_ROTATE_EN
                    w_rot_d   = (mode == 2'b10);
`endif
                    if (amt == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StShift;
                    end
                end
            end
            StShift: begin
                w_dout_d = w_shifted;
                w_rem_d  = r_rem - w_s;
                if (r_rem == w_s) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_dout  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
`ifdef MSHIFT_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_dout  <= w_dout_d;
            r_rem   <= w_rem_d;
            r_done  <= w_done_d;
            r_dir   <= w_dir_d;
            r_arith <= w_arith_d;
`ifdef MSHIFT_ROTATE_EN
            r_rot   <= w_rot_d;
`endif
        end
    end

    // All outputs come straight from registers.
    assign busy = (r_state == StShift);
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: tb/tb_multi_shifter_seq.sv
// ----------------------------------------------------------------------------
// tb_multi_shifter_seq
//
// Bench for multi_shifter_seq. It instantiates a WIDTH=8/STEP=1 DUT (a) and
// a WIDTH=8/STEP=4 DUT (b). Expected results come from a bit-at-a-time
// reference model, and expected latency is ceil(amt/STEP).
// ----------------------------------------------------------------------------
module tb_multi_shifter_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_start, a_dir, a_busy, a_done;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_amt;
    logic [1:0] a_mode;
    logic       b_start, b_dir, b_busy, b_done;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_amt;
    logic [1:0] b_mode;

    int n_checks = 0;
    int n_fail   = 0;

    multi_shifter_seq #(.WIDTH(8), .STEP(1)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (a_start),
        .din   (a_din),
        .amt   (a_amt),
        .dir   (a_dir),
        .mode  (a_mode),
        .busy  (a_busy),
        .done  (a_done),
        .dout  (a_dout)
    );

    multi_shifter_seq #(.WIDTH(8), .STEP(4)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (b_start),
        .din   (b_din),
        .amt   (b_amt),
        .dir   (b_dir),
        .mode  (b_mode),
        .busy  (b_busy),
        .done  (b_done),
        .dout  (b_dout)
    );

    // Reference model: apply the distance one bit at a time using the fill rules.
    function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic dr,
                                         input logic [1:0] m);
        logic [7:0] v;
        logic       msb;
        logic       rot;
        v   = d;
        msb = d[7];
`ifdef MSHIFT_ROTATE_EN
        rot = (m == 2'b10);
`else
        rot = 1'b0;
`endif
        for (int i = 0; i < a; i++) begin
            if (!dr) v = {v[6:0], (rot ? v[7] : 1'b0)};
            else     v = {(rot ? v[0] : ((m == 2'b01) ? msb : 1'b0)), v[7:1]};
        end
        return v;
    endfunction

    function automatic int exp_lat(input int a, input int step);
        return (a + step - 1) / step;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? b_done : a_done;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [7:0] d,
                         input logic [2:0] a, input logic dr, input logic [1:0] m);
        if (sel) begin
            b_start = st; b_din = d; b_amt = a; b_dir = dr; b_mode = m;
        end else begin
            a_start = st; a_din = d; a_amt = a; a_dir = dr; a_mode = m;
        end
    endtask

    // Issue one request and wait (bounded) for done. Inputs are scrambled
    // while busy. With collide set, an amt=0 request for 8'hFF is held on start
    // for the whole busy period, including the edge on which busy falls.
    task automatic do_op(input bit sel, input logic [7:0] d, input logic [2:0] a,
                         input logic dr, input logic [1:0] m, input bit collide,
                         output int lat, output int busy_cyc, output logic [7:0] res);
        @(negedge clk);
        drive(sel, 1'b1, d, a, dr, m);
        @(posedge clk);
        #1;
        if (collide) drive(sel, 1'b1, 8'hFF, 3'd0, ~dr, 2'b10);
        else         drive(sel, 1'b0, 8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
        lat      = 0;
        busy_cyc = 0;
        while (!cur_done(sel) && lat < 40) begin
            if (cur_busy(sel)) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        drive(sel, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        res = sel ? b_dout : a_dout;
    endtask

    task automatic test_reset;
        logic [7:0] r;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        #2;
        n_checks++;
        if ({a_dout, a_busy, a_done} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: dout=%h busy=%b done=%b, want 00/0/0",
                     a_dout, a_busy, a_done);
        end
        @(negedge clk);
        rst = 1'b0;
        // Mid-run reset: amt=5, after two shift edges.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hA5, 3'd5, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prebusy: busy=%b, want 1", a_busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_dout, a_busy, a_done} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_async: dout=%h busy=%b done=%b, want 00/0/0",
                     a_dout, a_busy, a_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        r = a_dout;
        n_checks++;
        if ({r, a_busy, a_done} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idle: dout=%h busy=%b done=%b, want 00/0/0",
                     r, a_busy, a_done);
        end
    endtask

    task automatic test_logical_left;
        int lat, bc;
        logic [7:0] r;
        do_op(1'b0, 8'b0101_1100, 3'd1, 1'b0, 2'b00, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== 8'b1011_1000 || lat !== 1 || bc !== 1) begin
            n_fail++;
            $display("FAIL logical_left: dout=%b lat=%0d busy=%0d, want 10111000 lat=1 busy=1",
                     r, lat, bc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (a_done !== 1'b0 || a_dout !== 8'b1011_1000) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b dout=%b, want 0 and held 10111000", a_done, a_dout);
        end
    endtask

    task automatic test_arith_right;
        int lat, bc;
        logic [7:0] r;
        do_op(1'b0, 8'b1011_0100, 3'd3, 1'b1, 2'b01, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== 8'b1111_0110 || lat !== 3) begin
            n_fail++;
            $display("FAIL arith_right: dout=%b lat=%0d, want 11110110 lat=3", r, lat);
        end
        do_op(1'b0, 8'b1011_0100, 3'd3, 1'b1, 2'b00, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== 8'b0001_0110 || lat !== 3) begin
            n_fail++;
            $display("FAIL logical_right: dout=%b lat=%0d, want 00010110 lat=3", r, lat);
        end
    endtask

    task automatic test_rotate;
        int lat, bc;
        logic [7:0] r, want;
`ifdef MSHIFT_ROTATE_EN
        want = 8'h18;
`else
        want = 8'h10;
`endif
        do_op(1'b0, 8'h81, 3'd4, 1'b0, 2'b10, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== want || lat !== 4) begin
            n_fail++;
            $display("FAIL rotate: dout=%h lat=%0d, want %h lat=4", r, lat, want);
        end
    endtask

    task automatic test_zero_amt;
        int lat, bc;
        logic [7:0] r;
        do_op(1'b0, 8'h3C, 3'd0, 1'b1, 2'b01, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== 8'h3C || lat !== 0 || bc !== 0) begin
            n_fail++;
            $display("FAIL zero_amt: dout=%h lat=%0d busy=%0d, want 3c lat=0 busy=0", r, lat, bc);
        end
    endtask

    task automatic test_collision;
        int lat, bc;
        logic [7:0] r;
        do_op(1'b0, 8'h96, 3'd5, 1'b0, 2'b00, 1'b1, lat, bc, r);
        n_checks++;
        if (r !== 8'hC0 || lat !== 5) begin
            n_fail++;
            $display("FAIL collision: dout=%h lat=%0d, want c0 lat=5", r, lat);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (a_dout !== 8'hC0 || a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_after: dout=%h done=%b busy=%b, want c0/0/0",
                     a_dout, a_done, a_busy);
        end
    endtask

    task automatic test_step4;
        int lat, bc;
        logic [7:0] r;
        do_op(1'b1, 8'h01, 3'd7, 1'b0, 2'b00, 1'b0, lat, bc, r);
        n_checks++;
        if (r !== 8'h80 || lat !== 2 || bc !== 2) begin
            n_fail++;
            $display("FAIL step4: dout=%h lat=%0d busy=%0d, want 80 lat=2 busy=2", r, lat, bc);
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [7:0] r, d, want;
        logic [2:0] a;
        logic       dr;
        logic [1:0] m;
        for (int i = 0; i < 60; i++) begin
            bit sel;
            sel  = (i % 2) == 1;
            d    = 8'($urandom);
            a    = 3'($urandom);
            dr   = 1'($urandom);
            m    = 2'($urandom);
            want = model(d, int'(a), dr, m);
            do_op(sel, d, a, dr, m, 1'b0, lat, bc, r);
            n_checks++;
            if (r !== want || lat !== exp_lat(int'(a), sel ? 4 : 1)) begin
                n_fail++;
                $display("FAIL random[%0d] step=%0d din=%h amt=%0d dir=%b mode=%b: dout=%h lat=%0d, want %h lat=%0d",
                         i, sel ? 4 : 1, d, a, dr, m, r, lat, want, exp_lat(int'(a), sel ? 4 : 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_logical_left();
        test_arith_right();
        test_rotate();
        test_zero_amt();
        test_collision();
        test_step4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
